// File: rtl/tanh_pair_scheduler.sv
// tanh_pair_scheduler
// Streams a vector of FP32 pre-activations from a source buffer through a
// dual-lane tanh unit two elements per transfer, and writes the results in
// order to a destination buffer.
//
// Handshake (tanh operand side): th_valid/th_ready. A pair transfers on any
// cycle where both are high. Once th_valid rises, th_din1/2 and th_valid stay
// constant until that transfer. Results come back on th_done, one cycle per
// pair, in issue order.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, src_base, dst_base   job launch (sampled only in IDLE)
//   len                         element count, 0..2^ADDR_W
//   busy, done, err             job status (err is sticky until next start)
//   rd_en, rd_addr, rd_data1/2  source buffer port (1-cycle read latency)
//   th_valid, th_ready,
//   th_din1/2                   operand pair to tanh unit
//   th_done, th_dout1/2         result pair from tanh unit
//   wr_en1/2, wr_addr,
//   wr_data1/2                  destination buffer write port
//   dbg_state                   current FSM state (IDLE=0 RUN=1 DRAIN=2 FIN=3)
module tanh_pair_scheduler #(
    parameter int ADDR_W       = 10,
    parameter int MAX_INFLIGHT = 48,
    parameter int CNT_W        = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data1,
    input  logic [31:0]       rd_data2,
    output logic              th_valid,
    input  logic              th_ready,
    output logic [31:0]       th_din1,
    output logic [31:0]       th_din2,
    input  logic              th_done,
    input  logic [31:0]       th_dout1,
    input  logic [31:0]       th_dout2,
    output logic              wr_en1,
    output logic              wr_en2,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data1,
    output logic [31:0]       wr_data2,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [CNT_W:0]    LP_MAX = (CNT_W+1)'(MAX_INFLIGHT);
    localparam logic [ADDR_W-1:0] LP_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  LP_C1  = CNT_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_pairs;
    logic              r_odd;
    logic [ADDR_W-1:0] r_rp;
    logic [ADDR_W-1:0] r_wp;
    logic              r_rd_pend;   // read issued last cycle, data arriving now
    logic              r_rd_last;   // that read fetches the final pair
    logic              r_ohr_full;
    logic [31:0]       r_din1;
    logic [31:0]       r_din2;
    logic [CNT_W-1:0]  r_inflight;
    logic              r_err;

    logic              w_start_acc;
    logic [ADDR_W:0]   w_len_p1;
    logic              w_accept;
    logic [CNT_W:0]    w_used;
    logic              w_rd;
    logic              w_wr;
    logic              w_wr_last;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_len_p1    = len + {{ADDR_W{1'b0}}, 1'b1};
    assign w_accept    = r_ohr_full && th_ready;

    // Credits count pairs at the tanh unit plus any pair already committed
    // upstream of it (held in the OHR or in flight from the source buffer).
    assign w_used = {1'b0, r_inflight}
                  + {{CNT_W{1'b0}}, r_ohr_full}
                  + {{CNT_W{1'b0}}, r_rd_pend};

    assign w_rd = (r_state == S_RUN) && (r_rp < r_pairs) && !r_rd_pend
               && (!r_ohr_full || w_accept) && (w_used < LP_MAX);

    // A result is only legitimate while a job holds credits.
    assign w_wr      = th_done && (r_state != S_IDLE) && (r_inflight != '0);
    assign w_wr_last = (r_wp == r_pairs - LP_ONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (len == '0) ? S_FIN : S_RUN;
            S_RUN:   if (r_rp == r_pairs) w_next = S_DRAIN;
            S_DRAIN: if (w_wr && (r_wp + LP_ONE == r_pairs)) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_pairs    <= '0;
            r_odd      <= 1'b0;
            r_rp       <= '0;
            r_wp       <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_last  <= 1'b0;
            r_ohr_full <= 1'b0;
            r_din1     <= '0;
            r_din2     <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rd_pend <= w_rd;
            r_rd_last <= w_rd && (r_rp == r_pairs - LP_ONE);

            if (w_start_acc) begin
                r_src   <= src_base;
                r_dst   <= dst_base;
                r_pairs <= w_len_p1[ADDR_W:1];
                r_odd   <= len[0];
                r_rp    <= '0;
                r_wp    <= '0;
                r_err   <= 1'b0;
            end else begin
                if (w_rd) r_rp <= r_rp + LP_ONE;
                if (w_wr) r_wp <= r_wp + LP_ONE;
            end

            // Stray result: applied after the start clear so it is never lost.
            if (th_done && !w_wr) r_err <= 1'b1;

            // Read gating guarantees the OHR is empty when read data lands.
            if (r_rd_pend) begin
                r_ohr_full <= 1'b1;
                r_din1     <= rd_data1;
                r_din2     <= (r_odd && r_rd_last) ? 32'h0 : rd_data2;
            end else if (w_accept) begin
                r_ohr_full <= 1'b0;
            end

            if (w_accept && !w_wr)      r_inflight <= r_inflight + LP_C1;
            else if (!w_accept && w_wr) r_inflight <= r_inflight - LP_C1;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);
    assign err       = r_err;
    assign dbg_state = r_state;

    assign rd_en   = w_rd;
    assign rd_addr = w_rd ? (r_src + {r_rp[ADDR_W-2:0], 1'b0}) : '0;

    assign th_valid = r_ohr_full;
    assign th_din1  = r_din1;
    assign th_din2  = r_din2;

    assign wr_en1   = w_wr;
    assign wr_en2   = w_wr && !(r_odd && w_wr_last);
    assign wr_addr  = w_wr ? (r_dst + {r_wp[ADDR_W-2:0], 1'b0}) : '0;
    assign wr_data1 = w_wr ? th_dout1 : '0;
    assign wr_data2 = wr_en2 ? th_dout2 : '0;

endmodule

// File: tb/tb_tanh_pair_scheduler.sv
// Bench for tanh_pair_scheduler: source buffer and tanh unit models,
// table-driven jobs plus hand-written stall and mid-run reset sequences.
module tb_tanh_pair_scheduler;

  localparam int AW   = 10;
  localparam int MAXI = 4;
  localparam int LAT  = 42;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          start;
  logic [AW-1:0] src_base, dst_base;
  logic [AW:0]   len;
  logic          busy, done, err, rd_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [31:0]   rd_data1, rd_data2, th_din1, th_din2;
  logic [31:0]   th_dout1, th_dout2, wr_data1, wr_data2;
  logic          th_valid, th_ready, th_done, wr_en1, wr_en2;
  logic [1:0]    dbg_state;

  tanh_pair_scheduler #(.ADDR_W(AW), .MAX_INFLIGHT(MAXI), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base),
    .dst_base(dst_base), .len(len), .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .th_valid(th_valid), .th_ready(th_ready), .th_din1(th_din1),
    .th_din2(th_din2), .th_done(th_done), .th_dout1(th_dout1),
    .th_dout2(th_dout2), .wr_en1(wr_en1), .wr_en2(wr_en2), .wr_addr(wr_addr),
    .wr_data1(wr_data1), .wr_data2(wr_data2), .dbg_state(dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [31:0] src_word(input logic [AW-1:0] a);
    return {6'h2A, a, 6'h15, ~a};
  endfunction

  function automatic logic [31:0] tanh_f(input logic [31:0] x);
    return {~x[31], x[30:0]} ^ 32'h0055_AA00;
  endfunction

  // ---------------- source buffer model ----------------
  always @(posedge clk) begin
    logic [AW-1:0] a2;
    a2 = rd_addr + AW'(1);
    if (rd_en) begin
      rd_data1 <= src_word(rd_addr);
      rd_data2 <= src_word(a2);
    end else begin
      rd_data1 <= 32'hBAD0_BAD1;
      rd_data2 <= 32'hBAD0_BAD2;
    end
  end

  // ---------------- tanh unit model ----------------
  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    int          due;
  } tanh_t;
  tanh_t tq[$];
  int cyc = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    th_done  <= 1'b0;
    th_dout1 <= 32'h0;
    th_dout2 <= 32'h0;
    if (tq.size() > 0 && tq[0].due <= cyc) begin
      th_done  <= 1'b1;
      th_dout1 <= tanh_f(tq[0].d1);
      th_dout2 <= tanh_f(tq[0].d2);
      void'(tq.pop_front());
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [AW+31:0] exp_q[$];      // expected writes {addr, data}
  logic [63:0]    exp_acc_q[$];  // expected operand pairs {din1, din2}
  int job_win, first_valid, rd_cnt, acc_cnt, wr1_cnt, wr2_cnt;
  int done_cnt, done_win, last_wr_win, tb_inflight, max_infl;
  int wr_total = 0;
  int dn_total = 0;
  int acc_win[64];

  always @(negedge clk) begin
    logic [63:0] e;
    logic [AW+31:0] w;
    tanh_t t;
    if (!rst_n) begin
      tb_inflight = 0;
    end else begin
      job_win++;
      if (th_valid && first_valid < 0) first_valid = job_win;
      if (rd_en) rd_cnt++;
      if (th_valid && th_ready) begin
        if (exp_acc_q.size() == 0) check("acc_unexpected", 64'd1, 64'd0);
        else begin
          e = exp_acc_q.pop_front();
          check("acc_operands", {th_din1, th_din2}, e);
        end
        if (acc_cnt < 64) acc_win[acc_cnt] = job_win;
        acc_cnt++;
        t.d1 = th_din1; t.d2 = th_din2; t.due = cyc + LAT;
        tq.push_back(t);
        tb_inflight++;
      end
      if (th_done) begin
        dn_total++;
        if (tb_inflight > 0) tb_inflight--;
      end
      if (tb_inflight > max_infl) max_infl = tb_inflight;
      if (wr_en1) begin
        wr1_cnt++; wr_total++; last_wr_win = job_win;
        if (exp_q.size() == 0) check("wr1_unexpected", {wr_addr, wr_data1}, 0);
        else begin
          w = exp_q.pop_front();
          check("wr1_addr_data", {wr_addr, wr_data1}, w);
        end
      end
      if (wr_en2) begin
        wr2_cnt++; wr_total++;
        if (exp_q.size() == 0) check("wr2_unexpected", {wr_addr, wr_data2}, 0);
        else begin
          w = exp_q.pop_front();
          check("wr2_addr_data", {wr_addr + AW'(1), wr_data2}, w);
        end
      end
      if (done) begin
        done_cnt++;
        done_win = job_win;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic setup_job(input int ln, input int s, input int d);
    logic [AW-1:0] sa, da;
    logic [31:0] w2;
    exp_q.delete();
    exp_acc_q.delete();
    first_valid = -1; rd_cnt = 0; acc_cnt = 0; wr1_cnt = 0; wr2_cnt = 0;
    done_cnt = 0; done_win = -1; last_wr_win = -1; max_infl = tb_inflight;
    for (int i = 0; i < ln; i++) begin
      sa = AW'(s + i);
      da = AW'(d + i);
      exp_q.push_back({da, tanh_f(src_word(sa))});
    end
    for (int k = 0; k < (ln + 1) / 2; k++) begin
      sa = AW'(s + 2 * k);
      w2 = (2 * k + 1 < ln) ? src_word(sa + AW'(1)) : 32'h0;
      exp_acc_q.push_back({src_word(sa), w2});
    end
  endtask

  task automatic start_job(input int ln, input int s, input int d);
    @(posedge clk); #1;
    start = 1'b1; src_base = AW'(s); dst_base = AW'(d); len = (AW+1)'(ln);
    job_win = -2;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_job(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_done_1cyc"}, 64'(done), 64'd0);
    check({tag, "_state_idle"}, 64'(dbg_state), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_err"}, 64'(err), 0);
    check({tag, "_rd"}, {rd_en, rd_addr}, 0);
    check({tag, "_th"}, {th_valid, th_din1, th_din2}, 0);
    check({tag, "_wr"}, {wr_en1, wr_en2, wr_addr, wr_data1, wr_data2}, 0);
  endtask

  typedef struct {
    int len;
    int src;
    int dst;
    int pairs;
    int wr2;
    int first_valid;
    bit tight;
  } vec_t;

  task automatic run_row(input string tag, input vec_t v);
    setup_job(v.len, v.src, v.dst);
    start_job(v.len, v.src, v.dst);
    wait_job(tag);
    check({tag, "_first_valid"}, 64'(first_valid), 64'(v.first_valid));
    check({tag, "_rd_cnt"}, 64'(rd_cnt), 64'(v.pairs));
    check({tag, "_acc_cnt"}, 64'(acc_cnt), 64'(v.pairs));
    check({tag, "_wr1_cnt"}, 64'(wr1_cnt), 64'(v.pairs));
    check({tag, "_wr2_cnt"}, 64'(wr2_cnt), 64'(v.wr2));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    if (v.len == 0) check({tag, "_done_win"}, 64'(done_win), 64'd0);
    else            check({tag, "_done_win"}, 64'(done_win), 64'(last_wr_win + 1));
    check({tag, "_exp_left"}, 64'(exp_q.size() + exp_acc_q.size()), 64'd0);
    check({tag, "_max_inflight_le"}, 64'(max_infl <= MAXI), 64'd1);
    check({tag, "_err"}, 64'(err), 64'd0);
    if (v.tight)
      for (int k = 0; k < acc_cnt && k < 64; k++)
        check($sformatf("%s_acc_win%0d", tag, k), 64'(acc_win[k]), 64'(2 + 2 * k));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs[6];
    int n, base_dn, base_wr;

    rst_n = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; len = '0;
    th_ready = 1'b1; job_win = 0; tb_inflight = 0; max_infl = 0;
    setup_job(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("post_reset");

    //          len  src    dst    P   wr2 fv  tight
    vecs[0] = '{8,  'h010, 'h100, 4,  4,  2,  1'b1};
    vecs[1] = '{5,  'h020, 'h200, 3,  2,  2,  1'b1};
    vecs[2] = '{0,  'h030, 'h300, 0,  0, -1,  1'b0};
    vecs[3] = '{1,  'h3FF, 'h3FF, 1,  0,  2,  1'b1};
    vecs[4] = '{7,  'h3FC, 'h3FE, 4,  3,  2,  1'b1};
    vecs[5] = '{20, 'h040, 'h140, 10, 10, 2,  1'b0};
    for (int r = 0; r < 6; r++) run_row($sformatf("row%0d", r), vecs[r]);
    // Credit-limited row must actually saturate the credit window.
    check("row5_max_inflight_eq", 64'(max_infl), 64'(MAXI));

    // Back-pressure: hold th_ready low for 10 cycles after first th_valid.
    setup_job(6, 'h050, 'h180);
    start_job(6, 'h050, 'h180);
    n = 0;
    while (!th_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_valid_seen", 64'(th_valid), 64'd1);
    th_ready = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 64'(th_valid), 64'd1);
      check("stall_din", {th_din1, th_din2}, {src_word(AW'('h050)), src_word(AW'('h051))});
      check("stall_no_rd", 64'(rd_en), 64'd0);
      @(posedge clk); #1;
    end
    th_ready = 1'b1;
    wait_job("stall");
    check("stall_acc_cnt", 64'(acc_cnt), 64'd3);
    check("stall_wr_cnt", 64'(wr1_cnt + wr2_cnt), 64'd6);
    check("stall_exp_left", 64'(exp_q.size() + exp_acc_q.size()), 64'd0);

    // Mid-run reset with three pairs at the tanh unit.
    setup_job(6, 'h070, 'h1C0);
    start_job(6, 'h070, 'h1C0);
    n = 0;
    while (tb_inflight < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_inflight_reached", 64'(tb_inflight), 64'd3);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrun_reset");
    exp_q.delete();
    exp_acc_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("midrun_reset_hold");
    rst_n = 1'b1;
    base_dn = dn_total;
    base_wr = wr_total;
    n = 0;
    while (dn_total < base_dn + 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_stray_dones", 64'(dn_total - base_dn), 64'd3);
    check("rst_err_set", 64'(err), 64'd1);
    check("rst_no_writes", 64'(wr_total - base_wr), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_err_sticky", 64'(err), 64'd1);

    // The next accepted start clears err.
    run_row("after_rst", '{2, 'h060, 'h160, 1, 1, 2, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
